// File: rtl/pic_pkg.sv
// Shared definitions for the PIC core: OCW2 command encodings, ISR acknowledge
// FSM states and the modulo level increment used by the priority logic.
package pic_pkg;

    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS       = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP       = 3'b111;

    typedef enum logic [0:0] {
        ISR_IDLE  = 1'b0,
        ISR_WAIT2 = 1'b1
    } isr_state_e;

    // idx+1 modulo n; also correct for any idx below 2n-1, so an
    // out-of-range level field still lands inside [0, n-1].
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        nxt = idx + 32'd1;
        if (nxt >= n) begin
            return nxt - n;
        end else begin
            return nxt;
        end
    endfunction

endpackage

// File: rtl/prio_resolver.sv
// Rotating priority encoder: finds the first set bit of vec scanning from base
// upward with wrap-around at NUM_IRQ (which need not be a power of two).
module prio_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [IDX_W-1:0]   base,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand_s;

    // Walk the levels in priority order; the first hit is latched and kept.
    always_comb begin
        found  = 1'b0;
        idx    = {IDX_W{1'b0}};
        cand_s = base;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!found && vec[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
            cand_s = IDX_W'(wrap_inc(32'(cand_s), NUM_IRQ));
        end
    end

endmodule

// File: rtl/isr_priority_ctrl.sv
// In-service register, priority resolution and two-pulse INTA acknowledge
// sequencing for the PIC core, with EOI handling and rotating priority.
module isr_priority_ctrl
    import pic_pkg::*;
#(
    parameter int NUM_IRQ      = 8,
    parameter int IDX_W        = $clog2(NUM_IRQ),
    parameter int SPURIOUS_IDX = NUM_IRQ - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irr_masked,
    input  logic               inta_pulse,
    input  logic               aeoi_en,
    input  logic               ocw2_valid,
    input  logic [2:0]         ocw2_cmd,
    input  logic [IDX_W-1:0]   ocw2_level,
    output logic               int_req,
    output logic [NUM_IRQ-1:0] isr,
    output logic [NUM_IRQ-1:0] irr_clr,
    output logic               vector_valid,
    output logic [IDX_W-1:0]   vector_idx,
    output logic [IDX_W-1:0]   prio_base,
    output logic [IDX_W-1:0]   last_serviced_idx
);

    localparam logic [NUM_IRQ-1:0] ONE_VEC  = {{(NUM_IRQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]   SPUR_IDX = IDX_W'(SPURIOUS_IDX);

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return ONE_VEC << i;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return IDX_W'(wrap_inc(32'(i), NUM_IRQ));
    endfunction

    // Distance of a level from the current base in priority order (0 = highest).
    function automatic logic [IDX_W-1:0] rank(input logic [IDX_W-1:0] i,
                                              input logic [IDX_W-1:0] b);
        int r;
        r = int'(i) - int'(b);
        if (r < 0) begin
            r = r + NUM_IRQ;
        end else begin
            r = r;
        end
        return IDX_W'(r);
    endfunction

    isr_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ack_idx_q, ack_idx_d;
    logic               ack_spur_q, ack_spur_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] irr_clr_q, irr_clr_d;
    logic               vector_valid_q, vector_valid_d;
    logic [IDX_W-1:0]   vector_idx_q, vector_idx_d;
    logic [IDX_W-1:0]   prio_base_q, prio_base_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               rot_aeoi_q, rot_aeoi_d;
    logic               int_req_q, int_req_d;

    logic               req_found_s, isr_found_s;
    logic [IDX_W-1:0]   req_idx_s, isr_idx_s;
    logic [IDX_W-1:0]   req_rank_s, isr_rank_s;
    logic [NUM_IRQ-1:0] isr_set_s, isr_clr_s;
    logic               lvl_ok_s;

    prio_resolver #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_req_res (
        .vec   (irr_masked),
        .base  (prio_base_q),
        .found (req_found_s),
        .idx   (req_idx_s)
    );

    prio_resolver #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_isr_res (
        .vec   (isr_q),
        .base  (prio_base_q),
        .found (isr_found_s),
        .idx   (isr_idx_s)
    );

    assign req_rank_s = rank(req_idx_s, prio_base_q);
    assign isr_rank_s = rank(isr_idx_s, prio_base_q);
    assign lvl_ok_s   = (32'(ocw2_level) < NUM_IRQ);

    // Next-state logic: acknowledge FSM first, then OCW2 so its rotation overrides AEOI.
    always_comb begin
        state_d        = state_q;
        ack_idx_d      = ack_idx_q;
        ack_spur_d     = ack_spur_q;
        irr_clr_d      = {NUM_IRQ{1'b0}};
        vector_valid_d = 1'b0;
        vector_idx_d   = vector_idx_q;
        prio_base_d    = prio_base_q;
        last_d         = last_q;
        rot_aeoi_d     = rot_aeoi_q;
        isr_set_s      = {NUM_IRQ{1'b0}};
        isr_clr_s      = {NUM_IRQ{1'b0}};
        int_req_d      = req_found_s && (!isr_found_s || (req_rank_s < isr_rank_s));

        case (state_q)
            ISR_IDLE: begin
                if (inta_pulse) begin
                    state_d = ISR_WAIT2;
                    if (req_found_s) begin
                        ack_idx_d  = req_idx_s;
                        ack_spur_d = 1'b0;
                        isr_set_s  = onehot(req_idx_s);
                        irr_clr_d  = onehot(req_idx_s);
                    end else begin
                        ack_idx_d  = SPUR_IDX;
                        ack_spur_d = 1'b1;
                    end
                end else begin
                    state_d = ISR_IDLE;
                end
            end
            ISR_WAIT2: begin
                if (inta_pulse) begin
                    state_d        = ISR_IDLE;
                    vector_valid_d = 1'b1;
                    vector_idx_d   = ack_idx_q;
                    if (aeoi_en && !ack_spur_q) begin
                        isr_clr_s = onehot(ack_idx_q);
                        if (rot_aeoi_q) begin
                            prio_base_d = next_idx(ack_idx_q);
                        end else begin
                            prio_base_d = prio_base_q;
                        end
                    end else begin
                        isr_clr_s = {NUM_IRQ{1'b0}};
                    end
                end else begin
                    state_d = ISR_WAIT2;
                end
            end
            default: begin
                state_d = ISR_IDLE;
            end
        endcase

        if (ocw2_valid) begin
            case (ocw2_cmd)
                OCW2_NS_EOI, OCW2_ROT_NS: begin
                    if (isr_found_s) begin
                        isr_clr_s = isr_clr_s | onehot(isr_idx_s);
                        last_d    = isr_idx_s;
                        if (ocw2_cmd == OCW2_ROT_NS) begin
                            prio_base_d = next_idx(isr_idx_s);
                        end else begin
                            prio_base_d = prio_base_d;
                        end
                    end else begin
                        last_d = last_q;
                    end
                end
                OCW2_SP_EOI, OCW2_ROT_SP: begin
                    if (lvl_ok_s) begin
                        isr_clr_s = isr_clr_s | onehot(ocw2_level);
                        last_d    = ocw2_level;
                        if (ocw2_cmd == OCW2_ROT_SP) begin
                            prio_base_d = next_idx(ocw2_level);
                        end else begin
                            prio_base_d = prio_base_d;
                        end
                    end else begin
                        last_d = last_q;
                    end
                end
                OCW2_SET_PRIO:     prio_base_d = next_idx(ocw2_level);
                OCW2_ROT_AEOI_SET: rot_aeoi_d  = 1'b1;
                OCW2_ROT_AEOI_CLR: rot_aeoi_d  = 1'b0;
                OCW2_NOP:          rot_aeoi_d  = rot_aeoi_q;
                default:           rot_aeoi_d  = rot_aeoi_q;
            endcase
        end else begin
            rot_aeoi_d = rot_aeoi_q;
        end

        // A set from the first INTA beats a same-cycle clear of the same bit.
        isr_d = (isr_q & ~isr_clr_s) | isr_set_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ISR_IDLE;
            ack_idx_q      <= {IDX_W{1'b0}};
            ack_spur_q     <= 1'b0;
            isr_q          <= {NUM_IRQ{1'b0}};
            irr_clr_q      <= {NUM_IRQ{1'b0}};
            vector_valid_q <= 1'b0;
            vector_idx_q   <= {IDX_W{1'b0}};
            prio_base_q    <= {IDX_W{1'b0}};
            last_q         <= {IDX_W{1'b0}};
            rot_aeoi_q     <= 1'b0;
            int_req_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ack_idx_q      <= ack_idx_d;
            ack_spur_q     <= ack_spur_d;
            isr_q          <= isr_d;
            irr_clr_q      <= irr_clr_d;
            vector_valid_q <= vector_valid_d;
            vector_idx_q   <= vector_idx_d;
            prio_base_q    <= prio_base_d;
            last_q         <= last_d;
            rot_aeoi_q     <= rot_aeoi_d;
            int_req_q      <= int_req_d;
        end
    end

    assign int_req           = int_req_q;
    assign isr               = isr_q;
    assign irr_clr           = irr_clr_q;
    assign vector_valid      = vector_valid_q;
    assign vector_idx        = vector_idx_q;
    assign prio_base         = prio_base_q;
    assign last_serviced_idx = last_q;

endmodule

// File: tb/tb_isr_priority_ctrl.sv
// Self-checking bench for isr_priority_ctrl: directed scenarios plus random
// stimulus on an 8-level and a 6-level instance against a behavioural model.
module tb_isr_priority_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] irr8, isr8, clr8;
    logic       inta8, aeoi8, ov8, ireq8, vv8;
    logic [2:0] cmd8, lvl8, vidx8, base8, last8;

    logic [5:0] irr6, isr6, clr6;
    logic       inta6, aeoi6, ov6, ireq6, vv6;
    logic [2:0] cmd6, lvl6, vidx6, base6, last6;

    isr_priority_ctrl #(.NUM_IRQ(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .irr_masked(irr8), .inta_pulse(inta8),
        .aeoi_en(aeoi8), .ocw2_valid(ov8), .ocw2_cmd(cmd8), .ocw2_level(lvl8),
        .int_req(ireq8), .isr(isr8), .irr_clr(clr8), .vector_valid(vv8),
        .vector_idx(vidx8), .prio_base(base8), .last_serviced_idx(last8)
    );

    isr_priority_ctrl #(.NUM_IRQ(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .irr_masked(irr6), .inta_pulse(inta6),
        .aeoi_en(aeoi6), .ocw2_valid(ov6), .ocw2_cmd(cmd6), .ocw2_level(lvl6),
        .int_req(ireq6), .isr(isr6), .irr_clr(clr6), .vector_valid(vv6),
        .vector_idx(vidx6), .prio_base(base6), .last_serviced_idx(last6)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int        n;
        bit [31:0] isr;
        bit [31:0] clr;
        int        base, last, ack, vidx;
        bit        rot, wait2, spur, vval, ireq;
    } mstate_t;

    mstate_t m8, m6;

    function automatic mstate_t mreset(int n);
        mstate_t r;
        r.n = n; r.isr = 0; r.clr = 0; r.base = 0; r.last = 0; r.ack = 0; r.vidx = 0;
        r.rot = 0; r.wait2 = 0; r.spur = 0; r.vval = 0; r.ireq = 0;
        return r;
    endfunction

    // Level of the first set bit in priority order from base, or -1.
    function automatic int mfirst(bit [31:0] v, int base, int n);
        for (int k = 0; k < n; k++) begin
            if (v[(base + k) % n]) return (base + k) % n;
        end
        return -1;
    endfunction

    function automatic mstate_t mstep(mstate_t s, bit [31:0] irr, bit inta, bit aeoi,
                                      bit ov, bit [2:0] cmd, int lvl);
        mstate_t   r;
        int        n, rw, it;
        bit [31:0] setv, clrv;
        r = s; n = s.n; setv = 0; clrv = 0;
        rw = mfirst(irr, s.base, n);
        it = mfirst(s.isr, s.base, n);
        r.ireq = (rw >= 0) && (it < 0 || ((rw - s.base + n) % n) < ((it - s.base + n) % n));
        r.clr = 0; r.vval = 0;
        if (inta && !s.wait2) begin
            r.wait2 = 1;
            if (rw >= 0) begin r.ack = rw; r.spur = 0; setv[rw] = 1; r.clr[rw] = 1; end
            else begin r.ack = n - 1; r.spur = 1; end
        end else if (inta && s.wait2) begin
            r.wait2 = 0; r.vval = 1; r.vidx = s.ack;
            if (aeoi && !s.spur) begin
                clrv[s.ack] = 1;
                if (s.rot) r.base = (s.ack + 1) % n;
            end
        end
        if (ov) begin
            case (cmd)
                3'd1, 3'd5: if (it >= 0) begin
                    clrv[it] = 1; r.last = it;
                    if (cmd == 3'd5) r.base = (it + 1) % n;
                end
                3'd3, 3'd7: if (lvl < n) begin
                    clrv[lvl] = 1; r.last = lvl;
                    if (cmd == 3'd7) r.base = (lvl + 1) % n;
                end
                3'd6: r.base = (lvl + 1) % n;
                3'd4: r.rot = 1;
                3'd0: r.rot = 0;
                default: ;
            endcase
        end
        r.isr = ((s.isr & ~clrv) | setv) & ((32'h1 << n) - 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        m8 = mstep(m8, 32'(irr8), inta8, aeoi8, ov8, cmd8, int'(lvl8));
        m6 = mstep(m6, 32'(irr6), inta6, aeoi6, ov6, cmd6, int'(lvl6));
        #1;
    endtask

    task automatic clear_inputs();
        irr8 = 0; inta8 = 0; aeoi8 = 0; ov8 = 0; cmd8 = 0; lvl8 = 0;
        irr6 = 0; inta6 = 0; aeoi6 = 0; ov6 = 0; cmd6 = 0; lvl6 = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        m8 = mreset(8);
        m6 = mreset(6);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_checks++; if (ireq8 !== 1'b0) begin n_fail++; $display("FAIL reset_int_req: got %b want 0", ireq8); end
        n_checks++; if (isr8 !== 8'h00) begin n_fail++; $display("FAIL reset_isr: got %h want 00", isr8); end
        n_checks++; if (clr8 !== 8'h00) begin n_fail++; $display("FAIL reset_irr_clr: got %h want 00", clr8); end
        n_checks++; if (vv8 !== 1'b0) begin n_fail++; $display("FAIL reset_vv: got %b want 0", vv8); end
        n_checks++; if ({vidx8, base8, last8} !== 9'h000) begin n_fail++; $display("FAIL reset_idx: got %h want 000", {vidx8, base8, last8}); end
        n_checks++; if ({isr6, base6} !== 9'h000) begin n_fail++; $display("FAIL reset_dut6: got %h want 000", {isr6, base6}); end
    endtask

    task automatic test_basic_ack();
        irr8 = 8'h0A;
        tick();
        n_checks++; if (ireq8 !== 1'b1) begin n_fail++; $display("FAIL ack_int_req_rise: got %b want 1", ireq8); end
        inta8 = 1; tick(); inta8 = 0;
        n_checks++; if (clr8 !== 8'h02) begin n_fail++; $display("FAIL ack_irr_clr: got %h want 02", clr8); end
        n_checks++; if (isr8 !== 8'h02) begin n_fail++; $display("FAIL ack_isr: got %h want 02", isr8); end
        irr8 = 8'h08;
        tick();
        n_checks++; if (ireq8 !== 1'b0) begin n_fail++; $display("FAIL ack_ir3_blocked: got %b want 0", ireq8); end
        n_checks++; if (clr8 !== 8'h00) begin n_fail++; $display("FAIL ack_clr_pulse: got %h want 00", clr8); end
        inta8 = 1; tick(); inta8 = 0;
        n_checks++; if (vv8 !== 1'b1) begin n_fail++; $display("FAIL ack_vv: got %b want 1", vv8); end
        n_checks++; if (vidx8 !== 3'd1) begin n_fail++; $display("FAIL ack_vidx: got %0d want 1", vidx8); end
        n_checks++; if (isr8 !== 8'h02) begin n_fail++; $display("FAIL ack_isr_hold: got %h want 02", isr8); end
        tick();
        n_checks++; if (vv8 !== 1'b0) begin n_fail++; $display("FAIL ack_vv_once: got %b want 0", vv8); end
        n_checks++; if (ireq8 !== 1'b0) begin n_fail++; $display("FAIL ack_ir3_still: got %b want 0", ireq8); end
    endtask

    task automatic test_ns_eoi();
        ov8 = 1; cmd8 = 3'b001; tick(); ov8 = 0;
        n_checks++; if (isr8 !== 8'h00) begin n_fail++; $display("FAIL nseoi_isr: got %h want 00", isr8); end
        n_checks++; if (last8 !== 3'd1) begin n_fail++; $display("FAIL nseoi_last: got %0d want 1", last8); end
        tick();
        n_checks++; if (ireq8 !== 1'b1) begin n_fail++; $display("FAIL nseoi_int_req: got %b want 1", ireq8); end
        irr8 = 0; tick();
    endtask

    task automatic test_aeoi_rotate();
        aeoi8 = 1; ov8 = 1; cmd8 = 3'b100; tick(); ov8 = 0;
        irr8 = 8'h20; inta8 = 1; tick();
        n_checks++; if (clr8 !== 8'h20) begin n_fail++; $display("FAIL aeoi_clr5: got %h want 20", clr8); end
        n_checks++; if (isr8 !== 8'h20) begin n_fail++; $display("FAIL aeoi_isr5: got %h want 20", isr8); end
        irr8 = 0; tick(); inta8 = 0;
        n_checks++; if (isr8 !== 8'h00) begin n_fail++; $display("FAIL aeoi_isr_clear: got %h want 00", isr8); end
        n_checks++; if (base8 !== 3'd6) begin n_fail++; $display("FAIL aeoi_base6: got %0d want 6", base8); end
        n_checks++; if (vidx8 !== 3'd5) begin n_fail++; $display("FAIL aeoi_vidx5: got %0d want 5", vidx8); end
        irr8 = 8'h84; inta8 = 1; tick();
        n_checks++; if (clr8 !== 8'h80) begin n_fail++; $display("FAIL aeoi_pick_ir7: got %h want 80", clr8); end
        irr8 = 0; tick(); inta8 = 0;
        n_checks++; if (vidx8 !== 3'd7) begin n_fail++; $display("FAIL aeoi_vidx7: got %0d want 7", vidx8); end
        n_checks++; if (base8 !== 3'd0) begin n_fail++; $display("FAIL aeoi_base_wrap: got %0d want 0", base8); end
        aeoi8 = 0; ov8 = 1; cmd8 = 3'b000; tick(); ov8 = 0;
    endtask

    task automatic test_wrap6();
        ov6 = 1; cmd6 = 3'b110; lvl6 = 3'd2; tick();
        n_checks++; if (base6 !== 3'd3) begin n_fail++; $display("FAIL wrap6_base3: got %0d want 3", base6); end
        lvl6 = 3'd4; tick();
        n_checks++; if (base6 !== 3'd5) begin n_fail++; $display("FAIL wrap6_base5: got %0d want 5", base6); end
        lvl6 = 3'd5; tick();
        n_checks++; if (base6 !== 3'd0) begin n_fail++; $display("FAIL wrap6_setprio: got %0d want 0", base6); end
        lvl6 = 3'd2; tick(); ov6 = 0;
        irr6 = 6'h20; inta6 = 1; tick();
        n_checks++; if (clr6 !== 6'h20) begin n_fail++; $display("FAIL wrap6_clr: got %h want 20", clr6); end
        irr6 = 0; tick(); inta6 = 0;
        n_checks++; if (isr6 !== 6'h20) begin n_fail++; $display("FAIL wrap6_isr: got %h want 20", isr6); end
        ov6 = 1; cmd6 = 3'b111; lvl6 = 3'd5; tick(); ov6 = 0;
        n_checks++; if (isr6 !== 6'h00) begin n_fail++; $display("FAIL wrap6_rotsp_isr: got %h want 00", isr6); end
        n_checks++; if (base6 !== 3'd0) begin n_fail++; $display("FAIL wrap6_rotsp_base: got %0d want 0", base6); end
        n_checks++; if (last6 !== 3'd5) begin n_fail++; $display("FAIL wrap6_rotsp_last: got %0d want 5", last6); end
    endtask

    task automatic test_spurious();
        irr8 = 8'h08; inta8 = 1; tick(); irr8 = 0; tick(); inta8 = 0;
        inta8 = 1; tick();
        n_checks++; if (clr8 !== 8'h00) begin n_fail++; $display("FAIL spur_no_clr: got %h want 00", clr8); end
        n_checks++; if (isr8 !== 8'h08) begin n_fail++; $display("FAIL spur_isr1: got %h want 08", isr8); end
        tick(); inta8 = 0;
        n_checks++; if (vidx8 !== 3'd7) begin n_fail++; $display("FAIL spur_vidx: got %0d want 7", vidx8); end
        n_checks++; if (vv8 !== 1'b1) begin n_fail++; $display("FAIL spur_vv: got %b want 1", vv8); end
        n_checks++; if (isr8 !== 8'h08) begin n_fail++; $display("FAIL spur_isr2: got %h want 08", isr8); end
    endtask

    task automatic test_back_to_back();
        ov8 = 1; cmd8 = 3'b100; tick();
        irr8 = 8'h04; inta8 = 1; cmd8 = 3'b011; lvl8 = 3'd2; tick();
        n_checks++; if (isr8 !== 8'h0C) begin n_fail++; $display("FAIL b2b_set_wins: got %h want 0c", isr8); end
        n_checks++; if (clr8 !== 8'h04) begin n_fail++; $display("FAIL b2b_clr: got %h want 04", clr8); end
        irr8 = 0; aeoi8 = 1; cmd8 = 3'b111; lvl8 = 3'd4; tick();
        inta8 = 0; ov8 = 0; aeoi8 = 0;
        n_checks++; if (isr8 !== 8'h08) begin n_fail++; $display("FAIL b2b_isr: got %h want 08", isr8); end
        n_checks++; if (base8 !== 3'd5) begin n_fail++; $display("FAIL b2b_ocw_rot_wins: got %0d want 5", base8); end
        n_checks++; if (last8 !== 3'd4) begin n_fail++; $display("FAIL b2b_last: got %0d want 4", last8); end
        ov8 = 1; cmd8 = 3'b000; tick(); ov8 = 0;
    endtask

    task automatic test_reset_mid();
        irr8 = 8'h10; inta8 = 1; tick(); inta8 = 0; irr8 = 0;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({isr8, base8} !== 11'h000) begin n_fail++; $display("FAIL rstmid_async: got %h want 000", {isr8, base8}); end
        m8 = mreset(8); m6 = mreset(6);
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        irr8 = 8'h01; inta8 = 1; tick(); inta8 = 0;
        n_checks++; if (vv8 !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_vv: got %b want 0", vv8); end
        n_checks++; if (isr8 !== 8'h01) begin n_fail++; $display("FAIL rstmid_isr: got %h want 01", isr8); end
        n_checks++; if (clr8 !== 8'h01) begin n_fail++; $display("FAIL rstmid_clr: got %h want 01", clr8); end
        irr8 = 0; tick();
        n_checks++; if (vv8 !== 1'b0) begin n_fail++; $display("FAIL rstmid_vv_later: got %b want 0", vv8); end
    endtask

    task automatic test_random();
        do_reset();
        repeat (600) begin
            irr8  = 8'($urandom);
            inta8 = ($urandom_range(3) == 0);
            aeoi8 = ($urandom_range(2) == 0);
            ov8   = ($urandom_range(3) == 0);
            cmd8  = 3'($urandom);
            lvl8  = 3'($urandom);
            irr6  = 6'($urandom);
            inta6 = ($urandom_range(3) == 0);
            aeoi6 = ($urandom_range(2) == 0);
            ov6   = ($urandom_range(3) == 0);
            cmd6  = 3'($urandom);
            lvl6  = 3'($urandom);
            tick();
            n_checks++; if (ireq8 !== m8.ireq) begin n_fail++; $display("FAIL rnd8_int_req: got %b want %b", ireq8, m8.ireq); end
            n_checks++; if (isr8 !== m8.isr[7:0]) begin n_fail++; $display("FAIL rnd8_isr: got %h want %h", isr8, m8.isr[7:0]); end
            n_checks++; if (clr8 !== m8.clr[7:0]) begin n_fail++; $display("FAIL rnd8_irr_clr: got %h want %h", clr8, m8.clr[7:0]); end
            n_checks++; if (vv8 !== m8.vval) begin n_fail++; $display("FAIL rnd8_vv: got %b want %b", vv8, m8.vval); end
            n_checks++; if (vidx8 !== 3'(m8.vidx)) begin n_fail++; $display("FAIL rnd8_vidx: got %0d want %0d", vidx8, m8.vidx); end
            n_checks++; if (base8 !== 3'(m8.base)) begin n_fail++; $display("FAIL rnd8_base: got %0d want %0d", base8, m8.base); end
            n_checks++; if (last8 !== 3'(m8.last)) begin n_fail++; $display("FAIL rnd8_last: got %0d want %0d", last8, m8.last); end
            n_checks++; if (ireq6 !== m6.ireq) begin n_fail++; $display("FAIL rnd6_int_req: got %b want %b", ireq6, m6.ireq); end
            n_checks++; if (isr6 !== m6.isr[5:0]) begin n_fail++; $display("FAIL rnd6_isr: got %h want %h", isr6, m6.isr[5:0]); end
            n_checks++; if (clr6 !== m6.clr[5:0]) begin n_fail++; $display("FAIL rnd6_irr_clr: got %h want %h", clr6, m6.clr[5:0]); end
            n_checks++; if (vv6 !== m6.vval) begin n_fail++; $display("FAIL rnd6_vv: got %b want %b", vv6, m6.vval); end
            n_checks++; if (vidx6 !== 3'(m6.vidx)) begin n_fail++; $display("FAIL rnd6_vidx: got %0d want %0d", vidx6, m6.vidx); end
            n_checks++; if (base6 !== 3'(m6.base)) begin n_fail++; $display("FAIL rnd6_base: got %0d want %0d", base6, m6.base); end
            n_checks++; if (last6 !== 3'(m6.last)) begin n_fail++; $display("FAIL rnd6_last: got %0d want %0d", last6, m6.last); end
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_basic_ack();
        test_ns_eoi();
        test_aeoi_rotate();
        test_wrap6();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/isr_priority_ctrl.md
Name: isr_priority_ctrl

Overview:
- Parametrised, fully synchronous in-service register (ISR) and priority resolver for the PIC core.
- Sits between the masked IRR and the bus/control logic.
- Resolves the highest-priority pending request against the levels already in service, and runs the two-pulse INTA acknowledge sequence.
- Sets and clears ISR bits for AEOI, non-specific and specific EOI, and supports rotating priority (rotate-on-EOI, rotate-in-AEOI, set-priority). The previous fixed 8-level design had no rotation.

Parameters:
- NUM_IRQ, 8, number of interrupt levels (2..32; need not be a power of two).
- IDX_W, $clog2(NUM_IRQ), width of a level index.
- SPURIOUS_IDX, NUM_IRQ-1, level reported when an acknowledge arrives with nothing pending.

Ports:
- clk  in  1  core clock. Reset is asynchronous and active-low; all state is in the clk domain.
- rst_n  in  1  asynchronous active-low reset.
- irr_masked  in  NUM_IRQ  pending requests, already masked by the IMR.
- inta_pulse  in  1  one-cycle strobe per INTA pulse, from the bus interface.
- aeoi_en  in  1  1 = automatic EOI (from ICW4).
- ocw2_valid  in  1  one-cycle strobe for an OCW2 write.
- ocw2_cmd  in  3  {R, SL, EOI} command bits.
- ocw2_level  in  IDX_W  level field for specific and set-priority commands.
- int_req  out  1  interrupt request to the CPU.
- isr  out  NUM_IRQ  in-service register.
- irr_clr  out  NUM_IRQ  one-hot, one-cycle pulse that clears the acknowledged IRR bit.
- vector_valid  out  1  one-cycle pulse after the second INTA.
- vector_idx  out  IDX_W  acknowledged level; held until the next acknowledge.
- prio_base  out  IDX_W  current highest-priority level.
- last_serviced_idx  out  IDX_W  last level cleared by any EOI.

Behaviour:
- Reset values: every output and all internal state are 0; the FSM is in IDLE. Assertion of rst_n low mid-sequence aborts the sequence, and no further pulses follow.
- Priority order: prio_base, prio_base+1, ..., wrapping modulo NUM_IRQ. The index after NUM_IRQ-1 is 0, including for non-power-of-two NUM_IRQ.
- Resolver (combinational):
  - req_win = first set bit of irr_masked in priority order.
  - isr_top = first set bit of isr in priority order.
  - int_req = req_win exists AND (isr empty OR req_win ranks strictly higher than isr_top).
  - int_req is registered, so it has 1 cycle of latency from an input change.
- FSM states: IDLE, WAIT2.
  - IDLE + inta_pulse, with req_win present: latch req_win into ack_idx, set isr[ack_idx], pulse irr_clr[ack_idx], go to WAIT2.
  - IDLE + inta_pulse, with no winner: ack_idx = SPURIOUS_IDX, isr and irr_clr unchanged, go to WAIT2.
  - WAIT2 + inta_pulse: vector_idx = ack_idx, vector_valid pulses for one cycle, go to IDLE.
    - If aeoi_en is set and the acknowledge was not spurious, clear isr[ack_idx] in the same cycle.
    - If rotate_aeoi is also set, prio_base = ack_idx+1 (modulo NUM_IRQ).
  - WAIT2 with no pulse: hold indefinitely.
- OCW2 decode on ocw2_valid; takes effect on the next clock edge.
  - 001 non-specific EOI: clear isr[isr_top]; last_serviced_idx = isr_top.
  - 011 specific EOI: clear isr[ocw2_level]; last_serviced_idx = ocw2_level.
  - 101 rotate on non-specific EOI: as 001, plus prio_base = isr_top+1.
  - 111 rotate on specific EOI: as 011, plus prio_base = ocw2_level+1.
  - 110 set priority: prio_base = ocw2_level+1; isr is unchanged.
  - 100 sets rotate_aeoi; 000 clears rotate_aeoi; 010 is a no-op.
- OCW2 edge cases:
  - Non-specific EOI (001 or 101) with isr empty: no change and no rotation.
  - Specific EOI with ocw2_level >= NUM_IRQ: ignored entirely.
  - Specific EOI on a level whose isr bit is already clear: still updates last_serviced_idx, and still rotates for 111.
- Simultaneous events:
  - OCW2 and inta_pulse in the same cycle: the EOI is evaluated against the pre-edge isr. The set from the first INTA and the clear from the EOI both apply; on the same bit, the set wins.
  - Rotation from an OCW2 and from AEOI in the same cycle: the OCW2 rotation wins.
- isr never has a bit set outside [NUM_IRQ-1:0].

Decomposition:
- Shared package `pic_pkg`:
  - OCW2 command localparams (OCW2_NS_EOI, OCW2_SP_EOI, OCW2_ROT_NS, OCW2_ROT_SP, OCW2_SET_PRIO, OCW2_ROT_AEOI_SET/CLR, OCW2_NOP).
  - FSM state enum: ISR_IDLE, ISR_WAIT2.
  - Function `wrap_inc(idx, n)` for the modulo increment.
- Sub-module `prio_resolver`:
  - Parametrised on NUM_IRQ.
  - Inputs: vector and base. Outputs: found flag and index.
  - Instantiated twice, once for irr_masked and once for isr.

Test Plan:
- Reset, then irr_masked=0x0A, two inta_pulses, aeoi_en=0: irr_clr=0x02 on the first pulse, isr=0x02, vector_idx=1, vector_valid pulses once, int_req stays 0 while IR3 pends behind IR1.
- With isr=0x02, ocw2 001: isr=0x00, last_serviced_idx=1, int_req rises next cycle for IR3.
- aeoi_en=1, rotate_aeoi set via 100, IR5 acknowledged: isr returns to 0 after the second pulse, prio_base=6. Then with IR2 and IR7 pending, the acknowledge selects IR7.
- NUM_IRQ=6, ocw2 110 with level=5: prio_base=0 (wrap). Ocw2 111 with level=5 and isr=0x20: isr=0, prio_base=0.
- inta_pulse with irr_masked=0: vector_idx=SPURIOUS_IDX, isr unchanged, no irr_clr pulse.
- Assert rst_n low while in WAIT2, release, then apply a single inta_pulse with IR0 pending: the FSM treats it as a first pulse, vector_valid does not pulse, isr=0x01.
